// File: rtl/dbg_view_seq_pkg.sv
// Shared types and constants for the debug value viewer: FSM states,
// the ack-timeout display word and the default segment animation table.
package dbg_view_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_SHOW = 2'd3
  } state_t;

  localparam logic [63:0] TIMEOUT_DATA = 64'h00000000DEADBEEF;

  // Raw segment words, one byte per digit: segment a sweeps out, segment d
  // sweeps back, then three whole-display frames.
  localparam int PAT_TABLE_LEN = 19;
  localparam logic [63:0] PAT_TABLE [PAT_TABLE_LEN] = '{
    64'h0000_0000_0000_0001, 64'h0000_0000_0000_0100,
    64'h0000_0000_0001_0000, 64'h0000_0000_0100_0000,
    64'h0000_0001_0000_0000, 64'h0000_0100_0000_0000,
    64'h0001_0000_0000_0000, 64'h0100_0000_0000_0000,
    64'h0800_0000_0000_0000, 64'h0008_0000_0000_0000,
    64'h0000_0800_0000_0000, 64'h0000_0008_0000_0000,
    64'h0000_0000_0800_0000, 64'h0000_0000_0008_0000,
    64'h0000_0000_0000_0800, 64'h0000_0000_0000_0008,
    64'h4040_4040_4040_4040, 64'h3F3F_3F3F_3F3F_3F3F,
    64'h8080_8080_8080_8080
  };

endpackage

// File: rtl/disp_pat_rom.sv
// Combinational lookup into the animation table; indices past the table
// or past PAT_DEPTH read as a blank display.
module disp_pat_rom
  import dbg_view_seq_pkg::*;
#(
  parameter int PAT_DEPTH = 19,
  parameter int IW        = (PAT_DEPTH > 1) ? $clog2(PAT_DEPTH) : 1
) (
  input  logic [IW-1:0] pat_idx_i,
  output logic [63:0]   pat_o
);

  always_comb begin
    pat_o = '0;
    for (int i = 0; i < PAT_TABLE_LEN; i++) begin
      if (i < PAT_DEPTH && int'(pat_idx_i) == i) pat_o = PAT_TABLE[i];
    end
  end

endmodule

// File: rtl/dbg_view_seq.sv
// Steps through per-channel source addresses (or a segment animation) and
// latches the returned word for the seven-segment driver.
module dbg_view_seq
  import dbg_view_seq_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int AW        = 5,
  parameter int DW        = 32,
  parameter int DIV_FAST  = 25,
  parameter int DIV_SLOW  = 27,
  parameter int PAT_DEPTH = 19,
  parameter int TO_CYC    = 255
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   speed_sel,
  input  logic                                   run,
  input  logic                                   step,
  input  logic                                   pat_mode,
  input  logic [NCH-1:0]                         ch_sel,
  input  logic [NCH*AW-1:0]                      ch_limit,
  output logic                                   rd_req,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] rd_ch,
  output logic [AW-1:0]                          rd_addr,
  input  logic                                   rd_ack,
  input  logic [DW-1:0]                          rd_data,
  output logic [63:0]                            disp_data,
  output logic                                   disp_mode,
  output logic [AW-1:0]                          cur_addr,
  output logic                                   busy,
  output logic                                   timeout_flag
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int IW = (PAT_DEPTH > 1) ? $clog2(PAT_DEPTH) : 1;
  localparam int TW = $clog2(TO_CYC + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [IW-1:0]   pat_idx_q, pat_idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [63:0]     disp_data_q, disp_data_d;
  logic [AW-1:0]   cur_addr_q, cur_addr_d;
  logic            timeout_q, timeout_d;
  logic            disp_mode_q;
  logic            step_s1_q, step_s2_q;
  logic [31:0]     presc_q;
  logic            presc_unused;
  logic            tick, trigger;
  logic [CW-1:0]   hot_idx;
  int              hot_cnt;
  logic [63:0]     pat_word;
  logic [NCH*AW-1:0] addr_all;
  logic [AW-1:0]   sel_addr;

  assign presc_unused = ^presc_q;
  assign tick    = speed_sel ? (&presc_q[DIV_SLOW-1:0]) : (&presc_q[DIV_FAST-1:0]);
  assign trigger = (run & tick) | (step_s1_q & ~step_s2_q);

  // Anything other than exactly one hot bit falls back to channel 0.
  always_comb begin
    hot_cnt = 0;
    hot_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_sel[i]) begin
        hot_cnt = hot_cnt + 1;
        hot_idx = CW'(i);
      end
    end
    if (hot_cnt != 1) hot_idx = '0;
  end

  disp_pat_rom #(.PAT_DEPTH(PAT_DEPTH), .IW(IW)) u_pat_rom (
    .pat_idx_i (pat_idx_q),
    .pat_o     (pat_word)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_addr
      logic [AW-1:0] cnt_q;
      logic [AW-1:0] limit;
      assign limit = ch_limit[gi*AW +: AW];
      assign addr_all[gi*AW +: AW] = cnt_q;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else if (state_q == ST_SHOW && ch_q == CW'(gi))
          cnt_q <= (cnt_q == limit) ? '0 : cnt_q + 1'b1;
      end
    end
  endgenerate

  assign sel_addr = addr_all[int'(ch_q)*AW +: AW];

  // The timer runs from REQ so that rd_req is high for exactly TO_CYC
  // cycles before the timeout word is shown; an ack in that cycle wins.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    pat_idx_d   = pat_idx_q;
    timer_d     = timer_q;
    disp_data_d = disp_data_q;
    cur_addr_d  = cur_addr_q;
    timeout_d   = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          if (pat_mode) begin
            disp_data_d = pat_word;
            pat_idx_d   = (pat_idx_q == IW'(PAT_DEPTH - 1)) ? '0 : pat_idx_q + 1'b1;
          end else begin
            state_d = ST_REQ;
            ch_d    = hot_idx;
            timer_d = '0;
          end
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
        timer_d = timer_q + 1'b1;
      end
      ST_WAIT: begin
        if (rd_ack) begin
          disp_data_d = 64'(rd_data);
          cur_addr_d  = sel_addr;
          state_d     = ST_SHOW;
        end else if (timer_q == TW'(TO_CYC - 1)) begin
          disp_data_d = TIMEOUT_DATA;
          timeout_d   = 1'b1;
          state_d     = ST_SHOW;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_SHOW: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      pat_idx_q   <= '0;
      timer_q     <= '0;
      disp_data_q <= 64'h1;
      cur_addr_q  <= '0;
      timeout_q   <= 1'b0;
      disp_mode_q <= 1'b0;
      step_s1_q   <= 1'b0;
      step_s2_q   <= 1'b0;
      presc_q     <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      pat_idx_q   <= pat_idx_d;
      timer_q     <= timer_d;
      disp_data_q <= disp_data_d;
      cur_addr_q  <= cur_addr_d;
      timeout_q   <= timeout_d;
      disp_mode_q <= pat_mode;
      step_s1_q   <= step;
      step_s2_q   <= step_s1_q;
      presc_q     <= presc_q + 32'd1;
    end
  end

  assign rd_req       = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign busy         = rd_req;
  assign rd_ch        = ch_q;
  assign rd_addr      = sel_addr;
  assign disp_data    = disp_data_q;
  assign disp_mode    = disp_mode_q;
  assign cur_addr     = cur_addr_q;
  assign timeout_flag = timeout_q;

endmodule

// File: tb/tb_dbg_view_seq.sv
// Directed bench for dbg_view_seq: browse, wrap, timeout, pattern
// animation, dropped triggers and asynchronous reset mid-transaction.
module tb_dbg_view_seq;

  logic        clk;
  logic        rstn;
  logic        speed_sel, run, step, pat_mode;
  logic [3:0]  ch_sel;
  logic [19:0] ch_limit;
  logic        rd_req;
  logic [1:0]  rd_ch;
  logic [4:0]  rd_addr;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic [63:0] disp_data;
  logic        disp_mode;
  logic [4:0]  cur_addr;
  logic        busy, timeout_flag;

  int checks = 0;
  int errors = 0;

  logic [63:0] pat_tab [19] = '{
    64'h0000_0000_0000_0001, 64'h0000_0000_0000_0100,
    64'h0000_0000_0001_0000, 64'h0000_0000_0100_0000,
    64'h0000_0001_0000_0000, 64'h0000_0100_0000_0000,
    64'h0001_0000_0000_0000, 64'h0100_0000_0000_0000,
    64'h0800_0000_0000_0000, 64'h0008_0000_0000_0000,
    64'h0000_0800_0000_0000, 64'h0000_0008_0000_0000,
    64'h0000_0000_0800_0000, 64'h0000_0000_0008_0000,
    64'h0000_0000_0000_0800, 64'h0000_0000_0000_0008,
    64'h4040_4040_4040_4040, 64'h3F3F_3F3F_3F3F_3F3F,
    64'h8080_8080_8080_8080
  };

  dbg_view_seq #(
    .NCH(4), .AW(5), .DW(32), .DIV_FAST(2), .DIV_SLOW(4),
    .PAT_DEPTH(19), .TO_CYC(255)
  ) dut (
    .clk(clk), .rstn(rstn), .speed_sel(speed_sel), .run(run), .step(step),
    .pat_mode(pat_mode), .ch_sel(ch_sel), .ch_limit(ch_limit),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data(rd_data), .disp_data(disp_data), .disp_mode(disp_mode),
    .cur_addr(cur_addr), .busy(busy), .timeout_flag(timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Leaves step low again on the cycle the trigger has been consumed.
  task automatic pulse_step();
    step = 1'b1;
    cyc(2);
    step = 1'b0;
  endtask

  task automatic serve(input int dly, input logic [31:0] data);
    cyc(dly);
    rd_ack  = 1'b1;
    rd_data = data;
    cyc(1);
    rd_ack  = 1'b0;
    rd_data = '0;
  endtask

  task automatic browse(input int ch, input int addr, input logic [31:0] data, input int dly);
    pulse_step();
    chk("req_rd_req", rd_req, 1);
    chk("req_rd_ch", rd_ch, ch);
    chk("req_rd_addr", rd_addr, addr);
    serve(dly, data);
    chk("show_disp", disp_data, {32'h0, data});
    chk("show_cur_addr", cur_addr, addr);
    chk("show_rd_req", rd_req, 0);
    cyc(1);
  endtask

  int n, upd, last;
  logic [63:0] prev;
  logic rdreq_seen;

  initial begin
    rstn = 1'b0; speed_sel = 1'b0; run = 1'b0; step = 1'b0; pat_mode = 1'b0;
    ch_sel = 4'b0000; rd_ack = 1'b0; rd_data = '0;
    ch_limit = {5'd7, 5'd7, 5'd3, 5'd7};
    cyc(3);
    chk("rst_disp", disp_data, 64'h1);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout_flag, 0);
    chk("rst_disp_mode", disp_mode, 0);
    chk("rst_rd_ch", rd_ch, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_cur_addr", cur_addr, 0);
    rstn = 1'b1;
    cyc(2);

    // ch1 walks 0..3 and wraps at its limit of 3
    ch_sel = 4'b0010;
    for (int k = 0; k < 4; k++) browse(1, k, 32'h100 + k, 2);
    chk("wrap_rd_addr", rd_addr, 0);
    chk("wrap_rd_ch", rd_ch, 1);

    // per-channel counters survive channel switches
    ch_sel = 4'b0001;
    browse(0, 0, 32'hA00, 2);
    browse(0, 1, 32'hA01, 2);
    ch_sel = 4'b0100;
    browse(2, 0, 32'hC00, 1);
    ch_sel = 4'b0001;
    browse(0, 2, 32'hA02, 3);

    // second step and ch_sel change while a read is outstanding
    pulse_step();
    chk("inflt_addr", rd_addr, 3);
    cyc(1);
    ch_sel = 4'b0100;
    pulse_step();
    chk("inflt_busy", busy, 1);
    chk("inflt_rd_ch", rd_ch, 0);
    serve(0, 32'h5503);
    chk("inflt_disp", disp_data, 64'h5503);
    chk("inflt_cur_addr", cur_addr, 3);
    cyc(5);
    chk("drop_rd_req", rd_req, 0);
    chk("drop_rd_ch", rd_ch, 0);
    chk("drop_rd_addr", rd_addr, 4);

    // stray ack while idle
    rd_ack = 1'b1; rd_data = 32'hFFFF;
    cyc(1);
    rd_ack = 1'b0; rd_data = '0;
    cyc(1);
    chk("stray_ack_disp", disp_data, 64'h5503);

    // multi-hot select falls back to channel 0
    ch_sel = 4'b0110;
    browse(0, 4, 32'h604, 1);

    // no ack: rd_req high for exactly TO_CYC cycles
    ch_sel = 4'b0010;
    pulse_step();
    n = 0;
    while (rd_req === 1'b1 && n < 1000) begin
      n++;
      cyc(1);
    end
    chk("to_req_cycles", n, 255);
    chk("to_disp", disp_data, 64'h00000000DEADBEEF);
    chk("to_flag", timeout_flag, 1);
    rd_ack = 1'b1; rd_data = 32'h1234;
    cyc(1);
    rd_ack = 1'b0; rd_data = '0;
    cyc(1);
    chk("to_late_ack", disp_data, 64'h00000000DEADBEEF);

    // pattern mode: mode registers without disturbing the display
    pat_mode = 1'b1;
    cyc(2);
    chk("pat_disp_mode", disp_mode, 1);
    chk("pat_no_clear", disp_data, 64'h00000000DEADBEEF);
    run = 1'b1;
    prev = disp_data; upd = 0; last = 0; rdreq_seen = 1'b0;
    for (int c = 1; c <= 200 && upd < 20; c++) begin
      cyc(1);
      if (rd_req !== 1'b0) rdreq_seen = 1'b1;
      if (disp_data !== prev) begin
        if (upd > 0) chk("pat_gap", c - last, 4);
        chk("pat_val", disp_data, pat_tab[upd % 19]);
        last = c;
        prev = disp_data;
        upd++;
      end
    end
    chk("pat_updates", upd, 20);
    chk("pat_rd_req", rdreq_seen, 0);
    chk("pat_to_held", timeout_flag, 1);
    run = 1'b0;
    pat_mode = 1'b0;
    cyc(2);

    // asynchronous reset in the middle of a read
    ch_sel = 4'b0010;
    pulse_step();
    cyc(1);
    chk("mid_busy", busy, 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_rd_req", rd_req, 0);
    chk("arst_disp", disp_data, 64'h1);
    chk("arst_timeout", timeout_flag, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rd_addr", rd_addr, 0);
    cyc(2);
    rstn = 1'b1;
    rd_ack = 1'b1; rd_data = 32'h777;
    cyc(1);
    rd_ack = 1'b0; rd_data = '0;
    cyc(2);
    chk("late_ack_disp", disp_data, 64'h1);
    chk("late_ack_req", rd_req, 0);
    chk("late_ack_cur", cur_addr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
